// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock through a single full-subtractor cell.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             borrowout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             bin;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic             x;
    logic             y;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] r_full;

    // Full-subtractor cell on the current LSBs; r_full is the result register after this bit lands at the MSB
    always_comb begin
        x      = a_sr[0];
        y      = b_sr[0];
        d      = x ^ y ^ bin;
        bout   = (~x & y) | (~(x ^ y) & bin);
        r_full = {d, r_sr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            cnt       <= '0;
            bin       <= 1'b0;
            diff      <= '0;
            borrowout <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bin   <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= SHIFT;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_full[WIDTH-1:1];
                    bin  <= bout;
                    cnt  <= cnt + 1'b1;
                    // Published outputs only move here, so they hold across the next operation's SHIFT
                    if (cnt == LAST) begin
                        diff      <= r_full;
                        borrowout <= bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow  <= (a_msb != b_msb) && (d != a_msb);
`endif
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic/latency model compared every cycle plus directed literal cases.
// Overflow checks are compiled in when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrowout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       overflow;
`endif

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int doneCount = 0;
    int lastDone = -1;
    bit sweepMode = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .ready(ready),
        .busy(busy),
        .done(done),
        .diff(diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .overflow(overflow),
`endif
        .borrowout(borrowout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: an operation is a fixed latency countdown whose result is plain wide arithmetic
    bit         mIdle = 1'b1;
    bit         mDone = 1'b0;
    int         mLeft = 0;
    logic [7:0] mDiff = 8'h00;
    logic       mBorrow = 1'b0;
    logic       mOvf = 1'b0;
    logic [8:0] pendWide;
    logic       pendOvf;
    int         sd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mIdle   = 1'b1;
            mDone   = 1'b0;
            mLeft   = 0;
            mDiff   = 8'h00;
            mBorrow = 1'b0;
            mOvf    = 1'b0;
        end else if (mDone) begin
            mDone = 1'b0;
            mIdle = 1'b1;
        end else if (mIdle) begin
            if (start) begin
                pendWide = {1'b0, a} - {1'b0, b};
                sd       = int'($signed(a)) - int'($signed(b));
                pendOvf  = (sd > 127) || (sd < -128);
                mIdle    = 1'b0;
                mLeft    = WIDTH;
            end
        end else begin
            mLeft--;
            if (mLeft == 0) begin
                mDone   = 1'b1;
                mDiff   = pendWide[7:0];
                mBorrow = pendWide[8];
                mOvf    = pendOvf;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("ready", ready, mIdle);
        checkOutput("busy", busy, !mIdle && !mDone);
        checkOutput("done", done, mDone);
        checkOutput("diff", diff, mDiff);
        checkOutput("borrowout", borrowout, mBorrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
        checkOutput("overflow", overflow, mOvf);
`endif
        if (done === 1'b1) begin
            doneCount++;
            if (sweepMode) begin
                if (lastDone >= 0) checkOutput("done spacing", cycleCnt - lastDone, 10);
                lastDone = cycleCnt;
            end
        end
    end

    // Caller sits 2 time units after a rising edge; returns at the same phase just after the accepting edge
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb);
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) checkOutput("ready wait", ready, 1);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < 40);
        if (lat >= 40) checkOutput("done wait", done, 1);
    endtask

    task automatic doOp(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] eDiff, input logic eBorrow);
        int lat;
        applyStimulus(va, vb);
        waitDone(lat);
        checkOutput({name, " latency"}, lat, 8);
        checkOutput({name, " diff"}, diff, eDiff);
        checkOutput({name, " borrow"}, borrowout, eBorrow);
        checkOutput({name, " model diff"}, mDiff, eDiff);
        @(posedge clk);
        #1;
        checkOutput({name, " ready back"}, ready, 1);
        checkOutput({name, " done low"}, done, 0);
        #1;
    endtask

    initial begin
        int lat;
        int c0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset ready", ready, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset diff", diff, 0);
        checkOutput("reset borrow", borrowout, 0);
        reset = 1'b0;
        @(posedge clk);
        #2;

        doOp("5-3", 8'h05, 8'h03, 8'h02, 1'b0);
        doOp("3-5", 8'h03, 8'h05, 8'hFE, 1'b1);
        doOp("0-FF", 8'h00, 8'hFF, 8'h01, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
        doOp("80-01", 8'h80, 8'h01, 8'h7F, 1'b0);
        checkOutput("80-01 overflow", overflow, 1);
        doOp("7F-01", 8'h7F, 8'h01, 8'h7E, 1'b0);
        checkOutput("7F-01 overflow", overflow, 0);
`endif

        // A start pulse during SHIFT must be dropped, not queued
        applyStimulus(8'h10, 8'h01);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        c0 = doneCount;
        waitDone(lat);
        checkOutput("ignore diff", diff, 8'h0F);
        checkOutput("ignore borrow", borrowout, 0);
        #1;
        repeat (15) begin
            @(posedge clk);
            #2;
        end
        checkOutput("ignore single done", doneCount - c0, 1);

        // Reset in the fourth SHIFT cycle discards the operation
        applyStimulus(8'h33, 8'h11);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset ready", ready, 1);
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset diff", diff, 0);
        checkOutput("midreset borrow", borrowout, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        c0 = doneCount;
        repeat (12) begin
            @(posedge clk);
            #2;
        end
        checkOutput("midreset no done", doneCount - c0, 0);
        doOp("AA-55", 8'hAA, 8'h55, 8'h55, 1'b0);

        // Back-to-back sweep with start held high
        sweepMode = 1'b1;
        lastDone = -1;
        for (int i = 0; i < 500; i++) begin
            applyStimulus(8'($urandom), 8'($urandom));
            start = (i < 499);
        end
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #2;
        end
        sweepMode = 1'b0;
        checkOutput("sweep idle", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
